pp_collector: RTL
=================

# pp_collector

Reassembles the 4x4 nibble partial products from the hex multiplier core into a full 16-bit 8x8 product. It is the return-path counterpart of the operand nibble-splitting stage. It accepts one partial product per handshake, tagged with its nibble-pair index, and shift-adds it into an accumulator. Once all four pairs have arrived, it presents the result on a valid/ready output port.

## Interface
Parameters:
- NIB_W, 4, operand nibble width
- PP_W, 8, partial-product width (2*NIB_W)
- RES_W, 16, result width (4*NIB_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort; discards any partial accumulation
- pp_valid  in  1  partial product offered
- pp_ready  out  1  collector can accept
- pp_idx  in  2  nibble pair: 0=LL, 1=LH, 2=HL, 3=HH
- pp_data  in  PP_W  unsigned 4x4 product
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  RES_W  assembled product
- dup_err  out  1  sticky: an index was delivered twice within one operation

## Operation
- Clock domain: all state is on clk. Reset: rst_n is asynchronous and active-low; clock is clk.
- A transfer occurs on a cycle where pp_valid and pp_ready are both 1.
- Shift amounts by pp_idx: 0 -> shift 0; 1 -> shift 4; 2 -> shift 4; 3 -> shift 8.
- Accumulator width is RES_W, with unsigned zero-extended addition. The maximum sum is 0xFE01, so no overflow is possible and no carry-out is kept.
- A 4-bit seen-mask records the indices received. Pairs may arrive in any order.
- Duplicate index (mask bit already set):
  - data is discarded and the accumulator is unchanged;
  - dup_err sets and stays set until clear or reset;
  - the transfer is still acknowledged.
- FSM states and transitions:
  - IDLE: pp_ready=1. On a transfer: add the product, set its mask bit, go to ACCUM.
  - ACCUM: pp_ready=1. On each transfer: add and set the mask bit. When the transfer completes mask=1111, go to DONE.
  - DONE: pp_ready=0, res_valid=1, res_data=accumulator. On res_ready=1: zero the accumulator and mask, go to IDLE.
- clear has highest priority:
  - next state is IDLE; accumulator, mask and dup_err are zeroed;
  - a coincident pp or res transfer is ignored;
  - res_valid drops the next cycle.
- Reset values: state IDLE, accumulator 0, mask 0, pp_ready 1, res_valid 0, res_data 0, dup_err 0.

## Timing
- pp_ready and res_valid are registered-state decodes with no combinational path from pp_valid or res_ready.
- Latency: the fourth unique transfer at cycle N gives res_valid=1 at N+1.
- Throughput: one operation per 5 cycles minimum (4 transfers + 1 result cycle with res_ready held high). The next pp transfer is possible at the cycle after the result handshake.
- res_data is stable while res_valid=1 and res_ready=0. The result holds indefinitely under backpressure.
- pp_data and pp_idx are sampled only on transfer cycles. Their values at other times are don't-care.

## Structure
- The shared package mul_pkg holds:
  - the state encoding (IDLE, ACCUM, DONE);
  - index constants IDX_LL/LH/HL/HH;
  - the shift function idx_to_shift.
- The package is reused by the operand-split stage for matching index encoding.
- A single module; no sub-module is needed. The shift-add stays inline.

## Test plan
- 0xAB*0xCD: send idx0=0x8F, idx1=0x84, idx2=0x82, idx3=0x78 in consecutive cycles with res_ready=1 -> res_data=0x88EF, res_valid for one cycle, dup_err=0.
- Out of order, 0xFF*0xFF: send idx3, idx0, idx2, idx1, each 0xE1 -> res_data=0xFE01.
- Backpressure: complete an operation with res_ready=0 for 10 cycles -> res_valid held, pp_ready=0, res_data stable. Raising res_ready then yields IDLE on the next cycle.
- Duplicate index: idx0=0x10 sent twice, then idx1..3=0 -> res_data=0x0010 and dup_err=1 stays set. A later clear pulse returns dup_err to 0.
- Abort: clear asserted after 2 transfers, or asserted in DONE together with res_ready -> no result transfer, the next operation starts from a zero accumulator, and the result is correct (e.g. 0x12*0x34=0x03A8).
- Async reset: assert rst_n low mid-ACCUM with no clock edge -> pp_ready=1, res_valid=0, res_data=0 immediately.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: definitions shared by the hex multiplier datapath.
//   - Collector FSM state encoding (ST_IDLE, ST_ACCUM, ST_DONE)
//   - Nibble-pair index encoding (IDX_LL/LH/HL/HH); the operand-split stage
//     uses the same values, so both ends agree on what each index means
//   - idx_to_shift: bit position at which a nibble-pair product is weighted
package mul_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] IDX_LL = 2'd0;
  localparam logic [1:0] IDX_LH = 2'd1;
  localparam logic [1:0] IDX_HL = 2'd2;
  localparam logic [1:0] IDX_HH = 2'd3;

  // LH and HL both mix one low and one high nibble, so they carry the same
  // weight of 2^4.
  function automatic logic [3:0] idx_to_shift(input logic [1:0] idx);
    logic [3:0] sh;
    sh = 4'd0;
    case (idx)
      IDX_LL:  sh = 4'd0;
      IDX_LH:  sh = 4'd4;
      IDX_HL:  sh = 4'd4;
      IDX_HH:  sh = 4'd8;
      default: sh = 4'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/pp_collector.sv
// pp_collector: reassembles four 4x4 nibble partial products into the
// 16-bit product of an 8x8 multiply.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort, discards any partial accumulation
//   pp_valid   partial product offered
//   pp_ready   collector can accept (high in IDLE and ACCUM)
//   pp_idx     nibble-pair index 0=LL 1=LH 2=HL 3=HH
//   pp_data    unsigned 4x4 product
//   res_valid  assembled result available (high in DONE)
//   res_ready  downstream accepts the result
//   res_data   assembled product
//   dup_err    sticky flag: an index arrived twice in one operation
module pp_collector
  import mul_pkg::*;
#(
  parameter int NIB_W = 4,
  parameter int PP_W  = 2 * NIB_W,
  parameter int RES_W = 4 * NIB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pp_valid,
  output logic             pp_ready,
  input  logic [1:0]       pp_idx,
  input  logic [PP_W-1:0]  pp_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             dup_err
);

  logic [1:0]       state;
  logic [RES_W-1:0] acc;
  logic [3:0]       mask;

  logic [RES_W-1:0] pp_ext;
  logic [3:0]       mask_nxt;
  logic             is_dup;

  // Weighted partial product. The largest possible total is 0xFE01, so the
  // plain RES_W-wide add below never needs a carry-out.
  assign pp_ext   = RES_W'(pp_data) << idx_to_shift(pp_idx);
  assign mask_nxt = mask | (4'b0001 << pp_idx);
  assign is_dup   = mask[pp_idx];

  // Handshake outputs decode registered state only, so there is no
  // combinational path from pp_valid or res_ready.
  assign pp_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign res_valid = (state == ST_DONE);
  // The accumulator is frozen in DONE, which keeps res_data stable under
  // backpressure; it reads 0 after reset and after every handshake.
  assign res_data  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mask    <= '0;
      dup_err <= 1'b0;
    end else if (clear) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mask    <= '0;
      dup_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (pp_valid) begin
            if (is_dup) begin
              // Acknowledged but discarded; operation keeps waiting for the
              // missing indices.
              dup_err <= 1'b1;
            end else begin
              acc   <= acc + pp_ext;
              mask  <= mask_nxt;
              state <= (&mask_nxt) ? ST_DONE : ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            acc   <= '0;
            mask  <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          acc   <= '0;
          mask  <= '0;
        end
      endcase
    end
  end

endmodule
